// File: rtl/stereo_frame_packer.sv
// Packs a raster-ordered 8-bit pixel stream into PIX_PER_WORD-pixel words for the
// stereo matcher frame buffer, capturing exactly one frame per request.

module stereo_frame_packer_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] pix_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst)     pix_q <= '0;
    else if (ld) pix_q <= d;
endmodule

module stereo_frame_packer #(
  parameter int IMG_WIDTH    = 240,
  parameter int IMG_HEIGHT   = 320,
  parameter int PIX_PER_WORD = 6
) (
  input  logic        clk_100mhz,
  input  logic        sys_rst,
  input  logic        pixel_valid_in,
  input  logic [7:0]  pixel_x_in,
  input  logic [8:0]  pixel_y_in,
  input  logic [7:0]  pixel_data_in,
  input  logic        frame_req_in,
  output logic        writing_out,
  output logic [13:0] addr_out,
  output logic [47:0] din_out,
  output logic        frame_done_out,
  output logic        busy_out,
  output logic        error_out
);
  localparam int              WORDS_PER_ROW = IMG_WIDTH / PIX_PER_WORD;
  localparam int              NUM_LANES     = PIX_PER_WORD - 1;
  localparam logic [7:0]      X_LAST        = 8'(IMG_WIDTH - 1);
  localparam logic [8:0]      Y_LAST        = 9'(IMG_HEIGHT - 1);
  localparam logic [13:0]     WPR           = 14'(WORDS_PER_ROW);
  localparam logic [2:0]      LANE_LAST     = 3'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  lane_q, lane_d;
  logic [7:0]  x_exp_q, x_exp_d;
  logic [8:0]  y_exp_q, y_exp_d;
  logic [5:0]  word_idx_q, word_idx_d;
  logic [13:0] row_base_q, row_base_d;
  logic [13:0] addr_q, addr_d;
  logic [47:0] din_q, din_d;
  logic        writing_q, writing_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;

  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lanes;
  logic                      is_origin, is_expected, start, accept;

  // Lanes 0..PIX_PER_WORD-2 are buffered; the last lane is taken straight from the input.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    stereo_frame_packer_lane u_lane (
      .clk(clk_100mhz), .rst(sys_rst), .ld(lane_we[k]),
      .d(pixel_data_in), .pix_q(lanes[k])
    );
  end

  assign is_origin   = pixel_valid_in && (pixel_x_in == 8'd0) && (pixel_y_in == 9'd0);
  assign is_expected = (pixel_x_in == x_exp_q) && (pixel_y_in == y_exp_q);

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    x_exp_d      = x_exp_q;
    y_exp_d      = y_exp_q;
    word_idx_d   = word_idx_q;
    row_base_d   = row_base_q;
    addr_d       = addr_q;
    din_d        = din_q;
    writing_d    = 1'b0;
    error_d      = 1'b0;
    frame_done_d = 1'b0;
    lane_we      = '0;
    start        = 1'b0;
    accept       = 1'b0;
    case (state_q)
      S_IDLE:    if (frame_req_in) state_d = S_ARMED;
      S_ARMED:   start = is_origin;
      S_CAPTURE: if (pixel_valid_in) begin
        if (is_expected) accept = 1'b1;
        else begin
          error_d = 1'b1;
          state_d = S_ARMED;
          start   = is_origin;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      lane_we[0] = 1'b1;
      lane_d     = 3'd1;
      x_exp_d    = 8'd1;
      y_exp_d    = '0;
      word_idx_d = '0;
      row_base_d = '0;
      state_d    = S_CAPTURE;
    end
    if (accept) begin
      if (lane_q == LANE_LAST) begin
        writing_d = 1'b1;
        addr_d    = row_base_q + 14'(word_idx_q);
        din_d     = {pixel_data_in, lanes};
        lane_d    = '0;
        if (pixel_x_in == X_LAST) begin
          x_exp_d    = '0;
          y_exp_d    = y_exp_q + 9'd1;
          word_idx_d = '0;
          row_base_d = row_base_q + WPR;
          if (pixel_y_in == Y_LAST) state_d = S_DONE;
        end else begin
          x_exp_d    = x_exp_q + 8'd1;
          word_idx_d = word_idx_q + 6'd1;
        end
      end else begin
        lane_we[lane_q] = 1'b1;
        lane_d          = lane_q + 3'd1;
        x_exp_d         = x_exp_q + 8'd1;
      end
    end
    // Busy covers the final-write cycle and drops together with the done pulse.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      x_exp_q      <= '0;
      y_exp_q      <= '0;
      word_idx_q   <= '0;
      row_base_q   <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      writing_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      x_exp_q      <= x_exp_d;
      y_exp_q      <= y_exp_d;
      word_idx_q   <= word_idx_d;
      row_base_q   <= row_base_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      writing_q    <= writing_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign writing_out    = writing_q;
  assign addr_out       = addr_q;
  assign din_out        = din_q;
  assign frame_done_out = frame_done_q;
  assign busy_out       = busy_q;
  assign error_out      = error_q;
endmodule
